// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage CPU: shadows downstream writers,
// selects ID-stage operand/flag forwarding and stalls IF/ID on load-use.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_set_flags,
  input  logic              id_use_flags,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              flag_fwd,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              set_flags;
  } ex_stage_t;

  // Only the fields a later decision reads are shadowed past EX: WB is never
  // forwarded, and MEM-stage mem_read/set_flags feed no hazard or flag path.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } mem_stage_t;

  localparam logic [REG_AW-1:0] XZR = '1;

  ex_stage_t  ex_q, ex_d;
  mem_stage_t mem_q, mem_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  fwd_sel_e sel_a, sel_b;
  logic     ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic     stall_w;

  function automatic logic writes(input logic              v,
                                  input logic              rw,
                                  input logic [REG_AW-1:0] rd,
                                  input logic [REG_AW-1:0] r);
    return v & rw & (rd == r) & (r != XZR);
  endfunction

  always_comb begin
    ex_hit_a  = writes(ex_q.valid,  ex_q.reg_write,  ex_q.rd,  id_rn);
    ex_hit_b  = writes(ex_q.valid,  ex_q.reg_write,  ex_q.rd,  id_rm);
    mem_hit_a = writes(mem_q.valid, mem_q.reg_write, mem_q.rd, id_rn);
    mem_hit_b = writes(mem_q.valid, mem_q.reg_write, mem_q.rd, id_rm);

    sel_a = FWD_RF;
    sel_b = FWD_RF;
    if (id_valid && id_use_a) begin
      if (ex_hit_a)       sel_a = FWD_EX;
      else if (mem_hit_a) sel_a = FWD_MEM;
    end
    if (id_valid && id_use_b) begin
      if (ex_hit_b)       sel_b = FWD_EX;
      else if (mem_hit_b) sel_b = FWD_MEM;
    end

    // A load in EX only has its data one cycle later, in MEM.
    stall_w = id_valid & ex_q.mem_read &
              ((id_use_a & ex_hit_a) | (id_use_b & ex_hit_b));
  end

  always_comb begin
    ex_d = '0;
    if (!stall_w) begin
      ex_d.valid     = id_valid;
      ex_d.rd        = id_rd & {REG_AW{id_valid}};
      ex_d.reg_write = id_reg_write & id_valid;
      ex_d.mem_read  = id_mem_read  & id_valid;
      ex_d.set_flags = id_set_flags & id_valid;
    end

    mem_d.valid     = ex_q.valid;
    mem_d.rd        = ex_q.rd;
    mem_d.reg_write = ex_q.reg_write;

    stall_count_d = stall_count_q;
    if (stall_w && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q          <= '0;
      mem_q         <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_a       = sel_a;
  assign fwd_b       = sel_b;
  assign flag_fwd    = id_valid & id_use_flags & ex_q.valid & ex_q.set_flags;
  assign stall       = stall_w;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl; a second instance with a
// 2-bit counter exercises stall_count saturation.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_a, id_use_b, id_reg_write, id_mem_read;
  logic       id_set_flags, id_use_flags;
  logic [4:0] id_rn, id_rm, id_rd;

  logic [1:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
  logic        flag_fwd, stall, flag_fwd_s, stall_s;
  logic [15:0] stall_count;
  logic [1:0]  stall_count_s;

  int checks = 0;
  int errors = 0;
  int unsigned nstall = 0;

  typedef struct {
    logic [1:0]  a;
    logic [1:0]  b;
    logic        ff;
    logic        st;
    int unsigned cnt;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_set_flags(id_set_flags), .id_use_flags(id_use_flags),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .flag_fwd(flag_fwd), .stall(stall),
    .stall_count(stall_count)
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_set_flags(id_set_flags), .id_use_flags(id_use_flags),
    .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .flag_fwd(flag_fwd_s), .stall(stall_s),
    .stall_count(stall_count_s)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic push_exp(input int a, input int b, input int ff, input int st);
    exp_t e;
    e.a   = 2'(a);
    e.b   = 2'(b);
    e.ff  = 1'(ff);
    e.st  = 1'(st);
    e.cnt = nstall;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    int unsigned sat;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard observed empty expected entry");
      return;
    end
    e = exp_q.pop_front();
    sat = (e.cnt > 3) ? 3 : e.cnt;
    cmp("fwd_a",       32'(fwd_a),         32'(e.a));
    cmp("fwd_b",       32'(fwd_b),         32'(e.b));
    cmp("flag_fwd",    32'(flag_fwd),      32'(e.ff));
    cmp("stall",       32'(stall),         32'(e.st));
    cmp("stall_count", 32'(stall_count),   e.cnt);
    cmp("sat_stall",   32'(stall_s),       32'(e.st));
    cmp("sat_fwd",     32'({fwd_a_s, fwd_b_s, flag_fwd_s}), 32'({e.a, e.b, e.ff}));
    cmp("sat_count",   32'(stall_count_s), sat);
  endtask

  task automatic drive(input int v, input int rn, input int rm, input int ua, input int ub,
                       input int rd, input int rw, input int mr, input int sf, input int uf);
    id_valid     = 1'(v);
    id_rn        = 5'(rn);
    id_rm        = 5'(rm);
    id_use_a     = 1'(ua);
    id_use_b     = 1'(ub);
    id_rd        = 5'(rd);
    id_reg_write = 1'(rw);
    id_mem_read  = 1'(mr);
    id_set_flags = 1'(sf);
    id_use_flags = 1'(uf);
  endtask

  // One ID cycle: drive at negedge, record expectation, compare 1 ns later.
  task automatic step(input int v, input int rn, input int rm, input int ua, input int ub,
                      input int rd, input int rw, input int mr, input int sf, input int uf,
                      input int ea, input int eb, input int eff, input int est);
    @(negedge clk);
    drive(v, rn, rm, ua, ub, rd, rw, mr, sf, uf);
    push_exp(ea, eb, eff, est);
    #1;
    check_out();
    if (est != 0) nstall++;
  endtask

  task automatic bubble();
    step(0,0,0,0,0,0,0,0,0,0, 0,0,0,0);
  endtask

  initial begin
    reset = 1'b0;
    drive(0,0,0,0,0,0,0,0,0,0);
    #2 reset = 1'b1;

    // Outputs held quiet under reset regardless of ID contents
    @(negedge clk);
    drive(1,1,1,1,1,1,1,1,1,1);
    push_exp(0,0,0,0);
    #1;
    check_out();
    drive(0,0,0,0,0,0,0,0,0,0);
    reset = 1'b0;

    // ADDS X1,X2,X3 ; ADDS X4,X1,X5 -> EX forward on A
    step(1,2,3,1,1,1,1,0,1,0, 0,0,0,0);
    step(1,1,5,1,1,4,1,0,1,0, 1,0,0,0);
    step(0,4,1,1,1,0,0,0,0,0, 0,0,0,0);
    bubble(); bubble();

    // ADDS X1 ; AND X9,X9,X9 ; EOR X4,X6,X1 -> MEM forward on B, then priority
    step(1,2,3,1,1,1,1,0,1,0, 0,0,0,0);
    step(1,9,9,1,1,9,1,0,0,0, 0,0,0,0);
    step(1,6,1,1,1,4,1,0,0,0, 0,2,0,0);
    step(1,9,4,1,1,5,1,0,1,0, 2,1,0,0);
    step(1,5,5,1,1,5,1,0,1,0, 1,1,0,0);
    step(1,5,0,1,1,6,1,0,1,0, 1,0,0,0);
    step(1,6,6,0,0,0,0,0,0,0, 0,0,0,0);
    bubble(); bubble();

    // LDUR X7 ; ADDS X8,X7,X7 -> one stall, then MEM forward
    step(1,0,0,1,0,7,1,1,0,0, 0,0,0,0);
    step(1,7,7,1,1,8,1,0,1,0, 1,1,0,1);
    step(1,7,7,1,1,8,1,0,1,0, 2,2,0,0);
    bubble(); bubble();

    // XZR is never a forwarding or stall source
    step(1,1,2,1,1,31,1,0,1,0, 0,0,0,0);
    step(1,31,31,1,1,3,1,0,1,0, 0,0,0,0);
    step(1,0,0,1,0,31,1,1,0,0, 0,0,0,0);
    step(1,31,31,1,1,2,1,0,1,0, 0,0,0,0);
    bubble(); bubble();

    // Flag forwarding only from an adjacent flag-setter
    step(1,2,3,1,1,1,1,0,1,0, 0,0,0,0);
    step(1,0,0,0,0,0,0,0,0,1, 0,0,1,0);
    step(1,2,3,1,1,1,1,0,1,0, 0,0,0,0);
    step(1,9,9,1,1,9,1,0,0,0, 0,0,0,0);
    step(1,0,0,0,0,0,0,0,0,1, 0,0,0,0);
    step(1,2,3,1,1,1,1,0,1,0, 0,0,0,0);
    step(0,0,0,0,0,0,0,0,0,1, 0,0,0,0);
    bubble(); bubble();

    // Repeated load-use pairs drive the small counter into saturation
    for (int k = 0; k < 4; k++) begin
      step(1,0,0,1,0,11+k,1,1,0,0, 0,0,0,0);
      step(1,11+k,0,1,0,20,1,0,0,0, 1,0,0,1);
      step(1,11+k,0,1,0,20,1,0,0,0, 2,0,0,0);
    end
    bubble();

    // Reset asserted in the middle of a load-use stall
    step(1,0,0,1,0,7,1,1,0,0, 0,0,0,0);
    step(1,7,7,1,1,8,1,0,1,0, 1,1,0,1);
    reset = 1'b1;
    nstall = 0;
    #1;
    push_exp(0,0,0,0);
    check_out();
    @(posedge clk);
    #1 reset = 1'b0;
    step(1,7,7,1,1,8,1,0,1,0, 0,0,0,0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
